multicycle_control: RTL

- Sequencing controller for a multi-cycle variant of the RV32I core.
- Drives PC, IR, memory, ALU-mux and writeback controls through FETCH/DECODE/EXEC/MEM/WB states.
- Handshakes with a single shared instruction/data memory port (mem_req/mem_ready).
- The immediate generator sits in the datapath, decodes IR opcode directly, and needs no select from this block.

---
 rtl/multicycle_control.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control.sv
// Sequencing controller for a multi-cycle RV32I core: steps FETCH/DECODE/EXEC/MEM/WB
// over a single shared memory port and drives the datapath mux/enable controls.
module multicycle_control #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [6:0]       opcode,
  input  logic             br_cond,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             iord,
  output logic             ir_write,
  output logic             mdr_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             reg_write,
  output logic [1:0]       wb_sel,
  output logic             illegal,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    OP_R, OP_I, OP_LW, OP_SW, OP_B, OP_JAL, OP_JALR, OP_BAD
  } op_class_t;

  localparam logic [6:0] OPC_R    = 7'b0110011;
  localparam logic [6:0] OPC_I    = 7'b0010011;
  localparam logic [6:0] OPC_LW   = 7'b0000011;
  localparam logic [6:0] OPC_SW   = 7'b0100011;
  localparam logic [6:0] OPC_B    = 7'b1100011;
  localparam logic [6:0] OPC_JAL  = 7'b1101111;
  localparam logic [6:0] OPC_JALR = 7'b1100111;

  localparam logic [1:0] PC_ALU     = 2'd0;
  localparam logic [1:0] PC_ALUOUT  = 2'd1;
  localparam logic [1:0] PC_ALU_ALN = 2'd2;
  localparam logic [1:0] A_PC       = 2'd0;
  localparam logic [1:0] A_RS1      = 2'd1;
  localparam logic [1:0] A_OLDPC    = 2'd2;
  localparam logic [1:0] B_RS2      = 2'd0;
  localparam logic [1:0] B_FOUR     = 2'd1;
  localparam logic [1:0] B_IMM      = 2'd2;
  localparam logic [1:0] ALU_ADD    = 2'd0;
  localparam logic [1:0] ALU_SUB    = 2'd1;
  localparam logic [1:0] ALU_FUNCT  = 2'd2;
  localparam logic [1:0] WB_ALUOUT  = 2'd0;
  localparam logic [1:0] WB_MDR     = 2'd1;
  localparam logic [1:0] WB_PC      = 2'd2;

  state_t    cur;
  op_class_t op_cls;
  state_t    after_retire;
  logic      is_ctl_flow;

  assign state = cur;

  always_comb begin
    op_cls = OP_BAD;
    case (opcode)
      OPC_R:    op_cls = OP_R;
      OPC_I:    op_cls = OP_I;
      OPC_LW:   op_cls = OP_LW;
      OPC_SW:   op_cls = OP_SW;
      OPC_B:    op_cls = OP_B;
      OPC_JAL:  op_cls = OP_JAL;
      OPC_JALR: op_cls = OP_JALR;
      default:  op_cls = OP_BAD;
    endcase
  end

  // run is only looked at when a new instruction would start
  assign after_retire = run ? S_FETCH : S_IDLE;
  assign is_ctl_flow  = (op_cls == OP_B) || (op_cls == OP_JAL) || (op_cls == OP_JALR);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur     <= S_IDLE;
      illegal <= 1'b0;
      retired <= '0;
    end else begin
      case (cur)
        S_IDLE: begin
          if (run)
            cur <= S_FETCH;
        end
        S_FETCH: begin
          if (mem_ready)
            cur <= S_DECODE;
        end
        S_DECODE: begin
          if (op_cls == OP_BAD) begin
            cur     <= S_TRAP;
            illegal <= 1'b1;
          end else begin
            cur <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (op_cls == OP_R || op_cls == OP_I) begin
            cur <= S_WB;
          end else if (op_cls == OP_LW || op_cls == OP_SW) begin
            cur <= S_MEM;
          end else if (is_ctl_flow) begin
            cur     <= after_retire;
            retired <= retired + CNT_W'(1);
          end else begin
            cur     <= S_TRAP;
            illegal <= 1'b1;
          end
        end
        S_MEM: begin
          if (mem_ready) begin
            if (op_cls == OP_SW) begin
              cur     <= after_retire;
              retired <= retired + CNT_W'(1);
            end else begin
              cur <= S_WB;
            end
          end
        end
        S_WB: begin
          cur     <= after_retire;
          retired <= retired + CNT_W'(1);
        end
        S_TRAP: begin
          cur <= S_TRAP;
        end
        default: begin
          cur <= S_IDLE;
        end
      endcase
    end
  end

  // Controls are decoded straight from state so an async reset drops every strobe at once
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    iord      = 1'b0;
    ir_write  = 1'b0;
    mdr_write = 1'b0;
    pc_write  = 1'b0;
    pc_src    = PC_ALU;
    alu_src_a = A_PC;
    alu_src_b = B_RS2;
    alu_op    = ALU_ADD;
    reg_write = 1'b0;
    wb_sel    = WB_ALUOUT;
    case (cur)
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_a = A_PC;
        alu_src_b = B_FOUR;
        alu_op    = ALU_ADD;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          pc_src   = PC_ALU;
        end
      end
      S_DECODE: begin
        alu_src_a = A_OLDPC;
        alu_src_b = B_IMM;
        alu_op    = ALU_ADD;
      end
      S_EXEC: begin
        case (op_cls)
          OP_R: begin
            alu_src_a = A_RS1;
            alu_src_b = B_RS2;
            alu_op    = ALU_FUNCT;
          end
          OP_I: begin
            alu_src_a = A_RS1;
            alu_src_b = B_IMM;
            alu_op    = ALU_FUNCT;
          end
          OP_LW, OP_SW: begin
            alu_src_a = A_RS1;
            alu_src_b = B_IMM;
            alu_op    = ALU_ADD;
          end
          OP_B: begin
            alu_src_a = A_RS1;
            alu_src_b = B_RS2;
            alu_op    = ALU_SUB;
            pc_write  = br_cond;
            pc_src    = PC_ALUOUT;
          end
          OP_JAL: begin
            pc_write  = 1'b1;
            pc_src    = PC_ALUOUT;
            reg_write = 1'b1;
            wb_sel    = WB_PC;
          end
          OP_JALR: begin
            alu_src_a = A_RS1;
            alu_src_b = B_IMM;
            alu_op    = ALU_ADD;
            pc_write  = 1'b1;
            pc_src    = PC_ALU_ALN;
            reg_write = 1'b1;
            wb_sel    = WB_PC;
          end
          default: begin
          end
        endcase
      end
      S_MEM: begin
        mem_req   = 1'b1;
        iord      = 1'b1;
        mem_we    = (op_cls == OP_SW);
        mdr_write = mem_ready && (op_cls == OP_LW);
      end
      S_WB: begin
        reg_write = 1'b1;
        wb_sel    = (op_cls == OP_LW) ? WB_MDR : WB_ALUOUT;
      end
      default: begin
      end
    endcase
  end

endmodule
